// File: rtl/manchester_rx.sv
// ---------------------------------------------------------------------------
// manchester_rx
//
// Purpose:
//   Manchester frame receiver. Each line bit is two half-bits (~b then b), so
//   the mid-bit edge's new level is the bit value. A frame is the preamble
//   1,0,1,0 followed by COUNTER_LENGTH payload bits, MSB first. The idle line
//   is a stream of 0 bits. Mid-bit edges are told apart from bit-boundary
//   edges by the time since the last accepted edge.
//
// Parameters:
//   COUNTER_LENGTH  payload bits per frame (>= 2)
//   HALF_BIT        clk cycles per half-bit (even, >= 4)
//
// Ports:
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   ena         in   block enable; low forces HUNT and abandons any frame
//   din         in   serial line, asynchronous to clk
//   data_out    out  last received payload (held until the next good frame)
//   data_valid  out  one-cycle pulse when data_out updates
//   frame_err   out  one-cycle pulse on preamble mismatch or timeout
//   locked      out  high while not in HUNT
//   err_count   out  saturating count of frame_err pulses
//
// Configuration:
//   MANCHESTER_RX_ERRCNT_EN  defined   -> err_count counts frame_err, stops at 255
//                            undefined -> err_count tied to 0
// ---------------------------------------------------------------------------
module manchester_rx #(
    parameter int COUNTER_LENGTH = 20,
    parameter int HALF_BIT       = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic                      din,
    output logic [COUNTER_LENGTH-1:0] data_out,
    output logic                      data_valid,
    output logic                      frame_err,
    output logic                      locked,
    output logic [7:0]                err_count
);

    localparam int GAP_MAX = 3 * HALF_BIT;
    localparam int GAP_THR = (3 * HALF_BIT) / 2;
    localparam int GAP_W   = $clog2(GAP_MAX + 1);
    localparam int CNT_W   = $clog2(COUNTER_LENGTH + 4);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic                      sync1_q, sync2_q, hist_q;
    logic [GAP_W-1:0]          gap_q, gap_d;
    logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
    logic [COUNTER_LENGTH-1:0] shift_q, shift_d;
    logic [COUNTER_LENGTH-1:0] data_out_q, data_out_d;
    logic                      data_valid_q, data_valid_d;
    logic                      frame_err_q, frame_err_d;

    logic line_edge_w;
    logic level_w;
    logic gap_long_w;
    logic gap_sat_w;
    logic accept_w;
    logic pre_match_w;
    logic pre_done_w;
    logic data_last_w;

    // Two-flop synchronizer plus a history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign line_edge_w = sync2_q ^ hist_q;
    assign level_w     = sync2_q;
    // 1.5 half-bits since the last accepted edge separates a mid-bit edge
    // (one full bit away) from a boundary edge (one half-bit away).
    assign gap_long_w  = (gap_q >= GAP_W'(GAP_THR));
    assign gap_sat_w   = (gap_q == GAP_W'(GAP_MAX));
    assign accept_w    = line_edge_w && gap_long_w;
    // Preamble tail expected as 0,1,0 for bit_cnt 0,1,2: the LSB of the index.
    assign pre_match_w = (level_w == bit_cnt_q[0]);
    assign pre_done_w  = (bit_cnt_q == CNT_W'(2));
    assign data_last_w = (bit_cnt_q == CNT_W'(COUNTER_LENGTH - 1));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        if (!ena) begin
            state_d = HUNT;
        end else begin
            case (state_q)
                HUNT: begin
                    if (accept_w && level_w) begin
                        state_d = PRE;
                    end
                end
                PRE: begin
                    if (accept_w) begin
                        if (!pre_match_w) begin
                            state_d = HUNT;
                        end else if (pre_done_w) begin
                            state_d = DATA;
                        end
                    end else if (gap_sat_w) begin
                        state_d = HUNT;
                    end
                end
                DATA: begin
                    if (accept_w) begin
                        if (data_last_w) begin
                            state_d = HUNT;
                        end
                    end else if (gap_sat_w) begin
                        state_d = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // FSM output / datapath next-state logic
    always_comb begin
        gap_d        = gap_sat_w ? gap_q : gap_q + GAP_W'(1);
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        if (!ena) begin
            gap_d     = '0;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                HUNT: begin
                    // Any edge restarts the gap measurement while hunting.
                    if (line_edge_w) begin
                        gap_d = '0;
                    end
                    bit_cnt_d = '0;
                end
                PRE: begin
                    if (accept_w) begin
                        gap_d = '0;
                        if (!pre_match_w) begin
                            frame_err_d = 1'b1;
                            bit_cnt_d   = '0;
                        end else if (pre_done_w) begin
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end else if (gap_sat_w) begin
                        frame_err_d = 1'b1;
                        bit_cnt_d   = '0;
                    end
                end
                DATA: begin
                    if (accept_w) begin
                        gap_d   = '0;
                        shift_d = {shift_q[COUNTER_LENGTH-2:0], level_w};
                        if (data_last_w) begin
                            data_out_d   = {shift_q[COUNTER_LENGTH-2:0], level_w};
                            data_valid_d = 1'b1;
                            bit_cnt_d    = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end else if (gap_sat_w) begin
                        frame_err_d = 1'b1;
                        bit_cnt_d   = '0;
                    end
                end
                default: begin
                    bit_cnt_d = '0;
                end
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            gap_q        <= gap_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign locked     = (state_q != HUNT);

`ifdef MANCHESTER_RX_ERRCNT_EN
    logic [7:0] err_cnt_q;

    // Counts on the same edge that raises frame_err; sticks at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else if (frame_err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_manchester_rx.sv
// ---------------------------------------------------------------------------
// tb_manchester_rx
//
// Directed-vector bench for manchester_rx (COUNTER_LENGTH=20, HALF_BIT=4).
// The stimulus process pushes each expected pulse (data_valid with payload,
// or frame_err with the held data_out) into a queue; a monitor pops and
// compares every time the receiver pulses. The expected err_count follows
// MANCHESTER_RX_ERRCNT_EN.
// ---------------------------------------------------------------------------
module tb_manchester_rx;

    localparam int L  = 20;
    localparam int HB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b1;
    logic          din = 1'b0;
    logic [L-1:0]  data_out;
    logic          data_valid;
    logic          frame_err;
    logic          locked;
    logic [7:0]    err_count;

    typedef struct packed {
        logic         is_err;
        logic [L-1:0] data;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int mid_cyc  = 0;
    int lock_cycles = 0;
    int exp_errs = 0;
    logic [L-1:0] exp_last = '0;

    manchester_rx #(
        .COUNTER_LENGTH(L),
        .HALF_BIT(HB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .din(din),
        .data_out(data_out),
        .data_valid(data_valid),
        .frame_err(frame_err),
        .locked(locked),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] exp_errcnt(input int n);
`ifdef MANCHESTER_RX_ERRCNT_EN
        return (n > 255) ? 8'd255 : 8'(n);
`else
        return 8'd0;
`endif
    endfunction

    // Monitor: every pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (locked) lock_cycles++;
            if (data_valid || frame_err) begin
                chk("pulse_exclusive", 32'(data_valid & frame_err), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, frame_err, data_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pulse_kind_err", 32'(frame_err), 32'(e.is_err));
                    chk("data_out", 32'(data_out), 32'(e.data));
                    chk("locked_after_pulse", 32'(locked), 32'd0);
                    if (data_valid) chk("valid_latency", 32'(cyc - mid_cyc), 32'd3);
                end
            end
        end
    end

    // All stimulus tasks start and end on a falling clock edge.
    task automatic send_bit(input logic b);
        din = ~b;
        repeat (HB) @(negedge clk);
        din = b;
        mid_cyc = cyc;
        repeat (HB) @(negedge clk);
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0);
    endtask

    task automatic send_preamble();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    endtask

    task automatic send_frame(input logic [L-1:0] p);
        exp_t e;
        e.is_err = 1'b0;
        e.data   = p;
        exp_q.push_back(e);
        exp_last = p;
        send_preamble();
        for (int i = L - 1; i >= 0; i--) send_bit(p[i]);
    endtask

    task automatic expect_err();
        exp_t e;
        e.is_err = 1'b1;
        e.data   = exp_last;
        exp_q.push_back(e);
        exp_errs++;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_data_out"},   32'(data_out),   32'd0);
        chk({tag, "_data_valid"}, 32'(data_valid), 32'd0);
        chk({tag, "_frame_err"},  32'(frame_err),  32'd0);
        chk({tag, "_locked"},     32'(locked),     32'd0);
        chk({tag, "_err_count"},  32'(err_count),  32'd0);
    endtask

    initial begin
        logic [L-1:0] pay;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Clean frame; locked spans preamble bit 0 mid-edge to last payload mid-edge
        send_idle(4);
        lock_cycles = 0;
        send_frame(20'h5A3C1);
        send_idle(2);
        chk("locked_cycles", 32'(lock_cycles), 32'(23 * 2 * HB));

        // Preamble 1,1,1,0: mismatch on the second accepted bit
        send_idle(2);
        expect_err();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        send_idle(3);
        chk("locked_after_bad_pre", 32'(locked), 32'd0);

        // Line frozen mid-payload: timeout. Freeze on a 1 so idle restart stays in HUNT.
        send_idle(2);
        send_preamble();
        pay = 20'h5A3C1;
        for (int i = L - 1; i >= L - 7; i--) send_bit(pay[i]);
        expect_err();
        repeat (16) @(negedge clk);
        send_idle(3);
        chk("err_count_2", 32'(err_count), 32'(exp_errcnt(exp_errs)));

        // ena dropped during payload bit 10, then a full frame
        send_idle(2);
        send_preamble();
        for (int i = L - 1; i >= L - 9; i--) send_bit(pay[i]);
        ena = 1'b0;
        @(negedge clk);
        chk("locked_ena_low", 32'(locked), 32'd0);
        send_bit(pay[L - 10]);
        send_idle(3);
        ena = 1'b1;
        send_idle(2);
        send_frame(20'hFFFFF);
        send_idle(2);

        // Reset mid-frame clears everything immediately
        send_idle(2);
        send_preamble();
        for (int i = L - 1; i >= L - 5; i--) send_bit(pay[i]);
        chk("locked_mid_frame", 32'(locked), 32'd1);
        rst_n = 1'b0;
        din = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_last = '0;
        exp_errs = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_idle(3);
        send_frame(20'h00001);
        send_idle(2);

        // 300 bad preambles (1,1 after an idle 0)
        for (int k = 0; k < 300; k++) begin
            expect_err();
            send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        end
        send_idle(3);
        chk("err_count_sat", 32'(err_count), 32'(exp_errcnt(exp_errs)));
        chk("data_out_held", 32'(data_out), 32'(20'h00001));
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/manchester_rx.md
MANCHESTER_RX -- requirements
Module: manchester_rx

Interface
REQ-001 Parameter COUNTER_LENGTH, default 20: payload bits per frame.
REQ-002 Parameter HALF_BIT, default 4: clk cycles per Manchester half-bit; even, >=4.
REQ-003 clk  input  1  single clock for all state; rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ena  input  1  block enable; low forces idle.
REQ-006 din  input  1  serial line, asynchronous to clk.
REQ-007 data_out  output  COUNTER_LENGTH  last received payload, MSB first on the line.
REQ-008 data_valid  output  1  one-cycle pulse when data_out updates.
REQ-009 frame_err  output  1  one-cycle pulse on preamble mismatch or timeout.
REQ-010 locked  output  1  high while in any state other than HUNT.
REQ-011 err_count  output  8  saturating frame_err count (see Configuration).

Function
REQ-012 Line coding SHALL be: each bit = two half-bits, first half = ~b, second half = b, so every bit has a mid-bit edge whose new level equals b.
REQ-013 Frame SHALL be: preamble 1,0,1,0, then COUNTER_LENGTH payload bits MSB first; idle line = stream of 0 bits.
REQ-014 din SHALL pass a 2-flop synchronizer plus one history flop; edge = sync output differs from history.
REQ-015 gap_cnt SHALL count clk cycles, saturating at 3*HALF_BIT.
REQ-016 States: HUNT, PRE, DATA.
REQ-017 HUNT: gap_cnt resets on every edge; an edge with gap_cnt >= 3*HALF_BIT/2 and new level 1 SHALL go to PRE with preamble bit 1 taken as received; any other edge stays in HUNT.
REQ-018 PRE/DATA: an edge with gap_cnt >= 3*HALF_BIT/2 is a mid-bit edge: accept bit = new level, reset gap_cnt; edges with a smaller gap_cnt SHALL be ignored without resetting gap_cnt.
REQ-019 PRE SHALL check the next three accepted bits against 0,1,0; on mismatch, pulse frame_err and go to HUNT on that cycle.
REQ-020 DATA SHALL shift accepted bits into a COUNTER_LENGTH shift register; after the last bit, data_out <= register, pulse data_valid, go to HUNT.
REQ-021 Timeout: in PRE/DATA, gap_cnt reaching 3*HALF_BIT SHALL pulse frame_err and go to HUNT.
REQ-022 Latency: data_valid SHALL be high in the 3rd clk cycle after the din transition of the last payload bit's mid-bit edge.
REQ-023 data_out SHALL hold its value until the next valid frame; it SHALL NOT change on an error.
REQ-024 ena low SHALL force HUNT and clear gap_cnt and the bit counter next cycle; no data_valid or frame_err pulse SHALL be raised for the abandoned frame.
REQ-025 data_valid and frame_err SHALL never be high in the same cycle.
REQ-026 Frames SHALL be separated by >=1 idle 0 bit; without this gap, frame detection is not guaranteed, but no spurious data_valid SHALL follow a preamble mismatch.

Reset
REQ-027 rst_n low SHALL asynchronously clear the state to HUNT and clear gap_cnt, the bit counter, the shift register, the synchronizer flops, data_out, data_valid, frame_err, locked and err_count to 0.
REQ-028 After rst_n rises, the first edge SHALL be processed under HUNT rules only.

Configuration
REQ-029 Macro MANCHESTER_RX_ERRCNT_EN defined: err_count SHALL increment on each frame_err pulse and saturate at 255; it SHALL be cleared only by reset.
REQ-030 Macro MANCHESTER_RX_ERRCNT_EN undefined: err_count SHALL be tied to 0 and no counter logic SHALL be present.

Verification
REQ-031 Idle zeros, then frame with payload 0x5A3C1 (HALF_BIT=4, 8 clk per bit) -> data_out=0x5A3C1, one data_valid pulse, locked high for 23 bits, frame_err never.
REQ-032 Preamble 1,1,1,0 after idle -> frame_err pulse on the second accepted bit, back to HUNT, data_out unchanged.
REQ-033 din frozen for 16 clk mid-payload -> frame_err pulse when gap_cnt hits 12; locked falls.
REQ-034 ena dropped during bit 10 of the payload, then frame 0xFFFFF -> no pulse for the aborted frame; next data_out=0xFFFFF.
REQ-035 rst_n asserted mid-frame -> all outputs 0 immediately; the following frame 0x00001 decodes correctly.
REQ-036 300 bad preambles with the macro defined -> err_count=255; with the macro undefined -> err_count=0.
